// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : N-master to 1-slave Wishbone classic arbiter. Round-robin
//               grant, bus-cycle locking on m_cyc, and a watchdog that
//               aborts a cycle when the slave stays silent too long.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int ADR_W       = 17,
    parameter int PORT_SIZE   = 32,
    parameter int GRANULARITY = 8,
    parameter int TIMEOUT     = 256,
    localparam int SEL_W      = PORT_SIZE / GRANULARITY
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // master side, master i occupies slice [i*W +: W]
    input  logic [N_MASTERS*ADR_W-1:0]     m_adr,
    input  logic [N_MASTERS*PORT_SIZE-1:0] m_dat_ms,
    input  logic [N_MASTERS*SEL_W-1:0]     m_sel,
    input  logic [N_MASTERS-1:0]           m_stb,
    input  logic [N_MASTERS-1:0]           m_cyc,
    input  logic [N_MASTERS-1:0]           m_we,
    output logic [N_MASTERS*PORT_SIZE-1:0] m_dat_sm,
    output logic [N_MASTERS-1:0]           m_ack,
    output logic [N_MASTERS-1:0]           m_err,
    output logic [N_MASTERS-1:0]           m_rty,
    // slave side
    output logic [ADR_W-1:0]               s_adr,
    output logic [PORT_SIZE-1:0]           s_dat_ms,
    output logic [SEL_W-1:0]               s_sel,
    output logic                           s_stb,
    output logic                           s_cyc,
    output logic                           s_we,
    input  logic [PORT_SIZE-1:0]           s_dat_sm,
    input  logic                           s_ack,
    input  logic                           s_err,
    input  logic                           s_rty,
    // debug
    output logic [N_MASTERS-1:0]           gnt
);

    localparam int IDX_W = $clog2(N_MASTERS);
    // a disabled watchdog still keeps a 1-bit counter, held at zero
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] own, own_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic [WD_W-1:0]  wd, wd_nxt;
    logic             bus_req;
    logic             slv_term;
    logic             wd_fire;

    // owner has an active strobe on the slave bus
    assign bus_req  = (state == OWNED) && m_cyc[own] && m_stb[own];
    assign slv_term = s_ack | s_err | s_rty;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            // last silent strobe cycle before the watchdog gives up
            assign wd_fire = bus_req && !slv_term &&
                             (wd == WD_W'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign wd_fire = 1'b0;
        end
    endgenerate

    // round-robin pick: first requester after the last owner, wrapping modulo N
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_c;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_c   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx   = (int'(last) + k) % N_MASTERS;
            idx_c = IDX_W'(idx);
            if (!any_req && m_cyc[idx_c]) begin
                winner  = idx_c;
                any_req = 1'b1;
            end
        end
    end

    // next-state logic: ownership, lock, abort and watchdog count
    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        last_nxt  = last;
        wd_nxt    = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWNED;
                    own_nxt   = winner;
                    last_nxt  = winner;
                end
            end
            OWNED: begin
                if (!m_cyc[own]) begin
                    state_nxt = IDLE;
                end else if (wd_fire) begin
                    state_nxt = ABORT;
                end else if (bus_req && !slv_term) begin
                    wd_nxt = wd + 1'b1;
                end
            end
            ABORT: begin
                // hold the owner off the bus until it gives up the cycle
                if (!m_cyc[own]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (TIMEOUT == 0) begin
            wd_nxt = '0;
        end
    end

    // state register; last resets to N-1 so master 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own   <= '0;
            last  <= IDX_W'(N_MASTERS - 1);
            wd    <= '0;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
            last  <= last_nxt;
            wd    <= wd_nxt;
        end
    end

    // bus muxing: request from owner, response broadcast/routed to owner only
    always_comb begin
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_stb    = 1'b0;
        s_cyc    = 1'b0;
        s_we     = 1'b0;
        m_dat_sm = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        gnt      = '0;
        if (state == OWNED) begin
            s_adr      = m_adr[int'(own)*ADR_W +: ADR_W];
            s_dat_ms   = m_dat_ms[int'(own)*PORT_SIZE +: PORT_SIZE];
            s_sel      = m_sel[int'(own)*SEL_W +: SEL_W];
            s_stb      = m_stb[own];
            s_cyc      = m_cyc[own];
            s_we       = m_we[own];
            m_dat_sm   = {N_MASTERS{s_dat_sm}};
            m_ack[own] = s_ack;
            m_err[own] = s_err | wd_fire;
            m_rty[own] = s_rty;
        end
        // an aborted owner still holds the grant until it drops m_cyc
        if (state != IDLE) begin
            gnt[own] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

N-master to 1-slave Wishbone classic arbiter with round-robin grant, bus-cycle locking and a bus-timeout watchdog. It sits between several Wishbone masters (CPU, DMA, debug bridge) and a shared register/peripheral bus built from the team's standard Wishbone port layout. Per-master ports are flattened into packed arrays; index i occupies slice `[i*W +: W]`.

## Interface
- `N_MASTERS`, 4: number of masters, 2..16.
- `ADR_W`, 17: full address width carried per master.
- `PORT_SIZE`, 32: data width.
- `GRANULARITY`, 8: select granularity; `SEL_W` = `PORT_SIZE/GRANULARITY`.
- `TIMEOUT`, 256: cycles of slave silence before abort; 0 disables the watchdog.

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_adr` in N×ADR_W: master addresses.
- `m_dat_ms` in N×PORT_SIZE: master write data.
- `m_sel` in N×SEL_W: master byte selects.
- `m_stb`, `m_cyc`, `m_we` in N: master strobes, cycles and write enables.
- `m_dat_sm` out N×PORT_SIZE: read data to masters.
- `m_ack`, `m_err`, `m_rty` out N: master terminations.
- `s_adr` out ADR_W, `s_dat_ms` out PORT_SIZE, `s_sel` out SEL_W, `s_stb` `s_cyc` `s_we` out 1: muxed slave request.
- `s_dat_sm` in PORT_SIZE, `s_ack` `s_err` `s_rty` in 1: slave response.
- `gnt` out N: one-hot current owner, for debug/perf counters.

## Operation
- States: IDLE, OWNED, ABORT. Registered state, owner index `own`, last owner `last`, watchdog counter `wd` (`$clog2(TIMEOUT+1)` bits).
- IDLE: `gnt`=0, slave outputs 0. If any `m_cyc` is high, pick the first requester scanning `last+1, last+2, …` modulo N. Next edge: `own`←winner, `last`←winner, go to OWNED.
- OWNED:
  - `s_*` request signals are combinationally driven from master `own`.
  - `s_dat_sm` is broadcast to all `m_dat_sm`.
  - `s_ack`/`s_err`/`s_rty` are routed only to master `own`; all other masters get 0.
  - Grant is locked while `m_cyc[own]`=1, regardless of other requests.
  - `m_cyc[own]`=0 at an edge → IDLE.
- Watchdog in OWNED:
  - `wd` increments each cycle with `s_cyc&s_stb` high and no slave termination.
  - `wd` clears on any termination, or when `s_stb`=0.
  - `wd`=TIMEOUT−1 with no termination this cycle: combinationally assert `m_err[own]` for that cycle, then go to ABORT at the edge.
- ABORT: `s_cyc`=`s_stb`=0 and no responses routed. Late slave acks are ignored. Remains until `m_cyc[own]`=0, then IDLE.
- Slave terminations are passed through unmodified. Simultaneous `ack`+`err` from the slave is forwarded as-is.
- Reset: state IDLE, `own`=0, `last`=N−1 (so master 0 wins first), `wd`=0.
- Every output is 0 in reset, and `m_dat_sm` is 0 while IDLE.

## Timing
- Grant latency: `m_cyc` rises in cycle t → `s_cyc` high in cycle t+1.
- Request/response path through the arbiter is combinational; no added latency once owned.
- Handover: owner drops `m_cyc` in cycle t → IDLE in t+1 (re-arbitration) → new owner on bus in t+2. There is one dead cycle between owners.
- A requester waits at most N−1 ownership periods.
- `TIMEOUT`=0: `wd` is held at 0 and ABORT is unreachable.
- `rst_n` asserted mid-cycle: all outputs go to 0 immediately (asynchronous) and the slave sees `s_cyc` drop without termination.

## Test plan
- Single read: N=4, master 2 asserts cyc/stb with `adr`=0x10; slave acks 2 cycles later with 0xDEADBEEF → `gnt`=0b0100 one cycle after request; `m_ack[2]` coincides with `s_ack`; `m_dat_sm[2]`=0xDEADBEEF; other acks stay 0.
- Round robin: all 4 masters request continuously, each dropping cyc after one ack → grant order 0,1,2,3,0, with exactly one idle cycle between owners.
- Lock: master 1 holds cyc across 3 writes (data 0x1,0x2,0x3) while master 0 requests → slave sees 3 writes from master 1 back-to-back; master 0 is granted only after master 1 drops cyc.
- Timeout: `TIMEOUT`=8, slave never responds → `m_err[own]` pulses one cycle in the 8th stb cycle; `s_cyc`=0 the next cycle; IDLE after master drops cyc; a late `s_ack` is not forwarded.
- Err/rty pass-through: slave returns err, then rty → routed only to the owner; `wd` cleared each time.
- Reset mid-transfer: assert `rst_n`=0 while OWNED → all outputs 0 asynchronously; after release, first grant goes to master 0.
